// File: rtl/flitzip_compressor.sv
// Flitzip NoC flit compressor: per-word zero / dictionary-hit / raw encoding,
// one register stage with valid/ready flow control on both sides.
module flitzip_compressor #(
   parameter  int FLIT_WIDTH = 128,
   parameter  int WORD_WIDTH = 32,
   parameter  int DICT_DEPTH = 8,
   localparam int NUM_WORDS  = FLIT_WIDTH / WORD_WIDTH,
   localparam int IDX_W      = $clog2(DICT_DEPTH),
   localparam int OUT_WIDTH  = NUM_WORDS * (2 + WORD_WIDTH),
   localparam int LEN_W      = $clog2(OUT_WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [FLIT_WIDTH-1:0] flit_in,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  comp_en,
   input  logic                  dict_flush,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic [LEN_W-1:0]      out_len,
   output logic                  out_valid,
   input  logic                  out_ready
);

   logic [WORD_WIDTH-1:0] dict_r       [DICT_DEPTH];
   logic [WORD_WIDTH-1:0] dict_nxt_s   [DICT_DEPTH];
   logic [DICT_DEPTH-1:0] dict_vld_r;
   logic [DICT_DEPTH-1:0] dict_vld_nxt_s;
   logic [IDX_W-1:0]      wr_ptr_r;
   logic [IDX_W-1:0]      wr_ptr_nxt_s;
   logic [NUM_WORDS-1:0]  raw_s;
   logic [OUT_WIDTH-1:0]  enc_data_s;
   logic [LEN_W-1:0]      enc_len_s;
   logic                  accept_s;

   assign in_ready = !out_valid || out_ready;
   assign accept_s = in_valid && in_ready;

   // Encode every word against the dictionary as it stands at acceptance
   // (a same-cycle flush makes it look empty); fields are appended MSB-first.
   always_comb begin
      logic [DICT_DEPTH-1:0]   vld_v;
      logic [WORD_WIDTH-1:0]   word_v;
      logic                    hit_v;
      logic                    match_v;
      logic [IDX_W-1:0]        idx_v;
      logic [2+WORD_WIDTH-1:0] field_v;
      logic [LEN_W-1:0]        flen_v;
      logic [OUT_WIDTH-1:0]    acc_v;
      logic [LEN_W-1:0]        len_v;
      vld_v   = dict_flush ? {DICT_DEPTH{1'b0}} : dict_vld_r;
      acc_v   = {OUT_WIDTH{1'b0}};
      len_v   = {LEN_W{1'b0}};
      raw_s   = {NUM_WORDS{1'b0}};
      word_v  = {WORD_WIDTH{1'b0}};
      hit_v   = 1'b0;
      match_v = 1'b0;
      idx_v   = {IDX_W{1'b0}};
      field_v = {(2+WORD_WIDTH){1'b0}};
      flen_v  = {LEN_W{1'b0}};
      for (int w = 0; w < NUM_WORDS; w++) begin
         word_v = flit_in[w*WORD_WIDTH +: WORD_WIDTH];
         hit_v  = 1'b0;
         idx_v  = {IDX_W{1'b0}};
         // Descending scan so the lowest matching index is the one kept.
         for (int e = DICT_DEPTH - 1; e >= 0; e--) begin
            match_v = vld_v[e] && (dict_r[e] == word_v);
            hit_v   = hit_v | match_v;
            idx_v   = match_v ? IDX_W'(e) : idx_v;
         end
         if (!comp_en) begin
            field_v  = {2'b10, word_v};
            flen_v   = LEN_W'(2 + WORD_WIDTH);
            raw_s[w] = 1'b1;
         end else if (word_v == {WORD_WIDTH{1'b0}}) begin
            field_v = {(2+WORD_WIDTH){1'b0}};
            flen_v  = LEN_W'(2);
         end else if (hit_v) begin
            field_v = {{(WORD_WIDTH-IDX_W){1'b0}}, 2'b01, idx_v};
            flen_v  = LEN_W'(2 + IDX_W);
         end else begin
            field_v  = {2'b10, word_v};
            flen_v   = LEN_W'(2 + WORD_WIDTH);
            raw_s[w] = 1'b1;
         end
         acc_v = (acc_v << flen_v) | OUT_WIDTH'(field_v);
         len_v = len_v + flen_v;
      end
      enc_data_s = acc_v << (LEN_W'(OUT_WIDTH) - len_v);
      enc_len_s  = len_v;
   end

   // Next dictionary state: flush clears first, then raw words of a
   // compressed accept are inserted in word order at the write pointer.
   always_comb begin
      logic [IDX_W-1:0] ptr_v;
      logic             ins_v;
      dict_nxt_s     = dict_r;
      dict_vld_nxt_s = dict_flush ? {DICT_DEPTH{1'b0}} : dict_vld_r;
      ptr_v          = dict_flush ? {IDX_W{1'b0}} : wr_ptr_r;
      ins_v          = 1'b0;
      for (int w = 0; w < NUM_WORDS; w++) begin
         ins_v                 = accept_s && comp_en && raw_s[w];
         dict_nxt_s[ptr_v]     = ins_v ? flit_in[w*WORD_WIDTH +: WORD_WIDTH] : dict_nxt_s[ptr_v];
         dict_vld_nxt_s[ptr_v] = ins_v | dict_vld_nxt_s[ptr_v];
         ptr_v                 = ptr_v + (ins_v ? IDX_W'(1) : IDX_W'(0));
      end
      wr_ptr_nxt_s = ptr_v;
   end

   // Dictionary storage, valid bits and write pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < DICT_DEPTH; e++) begin
            dict_r[e] <= {WORD_WIDTH{1'b0}};
         end
         dict_vld_r <= {DICT_DEPTH{1'b0}};
         wr_ptr_r   <= {IDX_W{1'b0}};
      end else begin
         dict_r     <= dict_nxt_s;
         dict_vld_r <= dict_vld_nxt_s;
         wr_ptr_r   <= wr_ptr_nxt_s;
      end
   end

   // Output stage: load on accept, drop valid after a transfer, else hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= {OUT_WIDTH{1'b0}};
         out_len   <= {LEN_W{1'b0}};
      end else if (accept_s) begin
         out_valid <= 1'b1;
         out_data  <= enc_data_s;
         out_len   <= enc_len_s;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= out_valid;
      end
   end

endmodule

// File: tb/tb_flitzip_compressor.sv
// Directed bench for flitzip_compressor: a bit-queue reference model of the
// encoding plus literal expectations for the hand-worked vectors.
module tb_flitzip_compressor;

   localparam int FW = 128;
   localparam int WW = 32;
   localparam int DD = 8;
   localparam int NW = FW / WW;
   localparam int OW = NW * (2 + WW);
   localparam int LW = $clog2(OW + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [FW-1:0] flit_in = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          comp_en = 1'b1;
   logic          dict_flush = 1'b0;
   logic [OW-1:0] out_data;
   logic [LW-1:0] out_len;
   logic          out_valid;
   logic          out_ready = 1'b1;

   flitzip_compressor #(.FLIT_WIDTH(FW), .WORD_WIDTH(WW), .DICT_DEPTH(DD)) dut (
      .clk(clk), .rst_n(rst_n), .flit_in(flit_in), .in_valid(in_valid),
      .in_ready(in_ready), .comp_en(comp_en), .dict_flush(dict_flush),
      .out_data(out_data), .out_len(out_len), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   int acc_cnt = 0;

   logic [WW-1:0] m_dict [DD];
   bit            m_vld  [DD];
   int            m_ptr = 0;
   logic [OW-1:0] exp_data_q [$];
   int            exp_len_q  [$];

   task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void model_clear();
      for (int e = 0; e < DD; e++) m_vld[e] = 0;
      m_ptr = 0;
   endfunction

   // Reference: build the compressed string bit by bit, then left-align it.
   function automatic void model_accept(input logic [FW-1:0] f, input bit ce, input bit fl);
      bit            bits [$];
      logic [WW-1:0] raws [$];
      logic [WW-1:0] word;
      logic [OW-1:0] d;
      int            hit;
      if (fl) model_clear();
      for (int w = 0; w < NW; w++) begin
         word = f[w*WW +: WW];
         hit = -1;
         if (ce) for (int e = 0; e < DD; e++)
            if (hit < 0 && m_vld[e] && m_dict[e] == word) hit = e;
         if (ce && word == 0) begin
            bits.push_back(0); bits.push_back(0);
         end else if (ce && hit >= 0) begin
            bits.push_back(0); bits.push_back(1);
            for (int b = 2; b >= 0; b--) bits.push_back(((hit >> b) & 1) != 0);
         end else begin
            bits.push_back(1); bits.push_back(0);
            for (int b = WW - 1; b >= 0; b--) bits.push_back(word[b]);
            if (ce) raws.push_back(word);
         end
      end
      foreach (raws[i]) begin
         m_dict[m_ptr] = raws[i];
         m_vld[m_ptr] = 1;
         m_ptr = (m_ptr + 1) % DD;
      end
      d = '0;
      foreach (bits[i]) d[OW-1-i] = bits[i];
      exp_data_q.push_back(d);
      exp_len_q.push_back(bits.size());
   endfunction

   // Track handshakes from the bench's own view of the pipeline.
   always @(posedge clk) begin
      if (rst_n) begin
         bit pend, xfer, acc;
         pend = exp_data_q.size() != 0;
         xfer = pend && out_ready;
         acc  = in_valid && (!pend || out_ready);
         if (xfer) begin
            void'(exp_data_q.pop_front());
            void'(exp_len_q.pop_front());
         end
         if (acc) begin
            model_accept(flit_in, comp_en, dict_flush);
            acc_cnt++;
         end else if (dict_flush) begin
            model_clear();
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   always begin
      @(negedge clk);
      #1;
      if (rst_n) begin
         check("out_valid", OW'(out_valid), OW'(exp_data_q.size() != 0));
         check("in_ready", OW'(in_ready), OW'(exp_data_q.size() == 0 || out_ready));
         if (out_valid && exp_data_q.size() != 0) begin
            check("out_data", out_data, exp_data_q[0]);
            check("out_len", OW'(out_len), OW'(exp_len_q[0]));
         end
      end
   end

   task automatic send(input logic [FW-1:0] f, input bit ce, input bit fl);
      int start;
      start = acc_cnt;
      flit_in = f; comp_en = ce; dict_flush = fl; in_valid = 1'b1;
      for (int k = 0; k < 50 && acc_cnt == start; k++) @(negedge clk);
      if (acc_cnt == start) begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout: got no accept expected accept");
      end
      in_valid = 1'b0; dict_flush = 1'b0;
   endtask

   localparam logic [FW-1:0] F_FAC = 128'hFAC68915ACEF098F;
   localparam logic [FW-1:0] F_A = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
   localparam logic [FW-1:0] F_B = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555};
   localparam logic [FW-1:0] F_C = {32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA, 32'h99999999};
   localparam logic [FW-1:0] F_D = {32'h00000000, 32'h55555555, 32'h99999999, 32'h11111111};

   initial begin
      int start;
      model_clear();
      repeat (2) @(negedge clk);
      check("rst_out_valid", OW'(out_valid), OW'(1'b0));
      check("rst_out_data", out_data, '0);
      check("rst_out_len", OW'(out_len), OW'(8'd0));
      check("rst_in_ready", OW'(in_ready), OW'(1'b1));
      rst_n = 1'b1;
      @(negedge clk);

      send('0, 1'b1, 1'b0);
      check("zero_len", OW'(out_len), OW'(8'd8));
      check("zero_data", out_data, '0);
      send(F_FAC, 1'b1, 1'b0);
      check("fac_len", OW'(out_len), OW'(8'd72));
      check("fac_top", OW'(out_data[OW-1 -: 34]), OW'({2'b10, 32'hACEF098F}));
      send(F_FAC, 1'b1, 1'b0);
      check("fac_hit_len", OW'(out_len), OW'(8'd14));
      check("fac_hit_top", OW'(out_data[OW-1 -: 14]), OW'(14'b01000010010000));

      send(F_A, 1'b1, 1'b1);
      check("wrap_a_len", OW'(out_len), OW'(8'd136));
      send(F_B, 1'b1, 1'b0);
      send(F_C, 1'b1, 1'b0);
      check("wrap_c_len", OW'(out_len), OW'(8'd136));
      send(F_D, 1'b1, 1'b0);
      check("wrap_d_len", OW'(out_len), OW'(8'd46));
      check("wrap_d_top", OW'(out_data[OW-1 -: 46]),
            OW'({2'b10, 32'h11111111, 2'b01, 3'd0, 2'b01, 3'd4, 2'b00}));

      send(F_D, 1'b0, 1'b0);
      check("bypass_len", OW'(out_len), OW'(8'd136));
      check("bypass_data", out_data,
            {2'b10, 32'h11111111, 2'b10, 32'h99999999, 2'b10, 32'h55555555, 2'b10, 32'h00000000});

      send(F_C, 1'b1, 1'b1);
      check("flush_acc_len", OW'(out_len), OW'(8'd136));
      send(F_C, 1'b1, 1'b0);
      check("post_flush_hit_len", OW'(out_len), OW'(8'd20));
      check("post_flush_hit_top", OW'(out_data[OW-1 -: 20]),
            OW'({2'b01, 3'd0, 2'b01, 3'd1, 2'b01, 3'd2, 2'b01, 3'd3}));
      dict_flush = 1'b1;
      @(negedge clk);
      dict_flush = 1'b0;
      send(F_C, 1'b1, 1'b0);
      check("idle_flush_len", OW'(out_len), OW'(8'd136));

      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; comp_en = 1'b1;
      flit_in = {32'h0, 32'hDEADBEEF, 32'h0, 32'h12345678};
      start = acc_cnt;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_in_ready", OW'(in_ready), OW'(1'b0));
      end
      check("stall_accepts", OW'(acc_cnt - start), OW'(1));
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         flit_in = {32'h0, 32'hDEADBEEF, 32'(i + 1), 32'h12345678};
         @(negedge clk);
      end
      check("release_accepts", OW'(acc_cnt - start), OW'(5));
      in_valid = 1'b0;
      @(negedge clk);

      out_ready = 1'b0;
      send(F_FAC, 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", OW'(out_valid), OW'(1'b0));
      check("midrst_out_len", OW'(out_len), OW'(8'd0));
      exp_data_q.delete();
      exp_len_q.delete();
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      send(F_FAC, 1'b1, 1'b0);
      check("midrst_dict_len", OW'(out_len), OW'(8'd72));

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
